// File: rtl/multi_cycle_adder_ctrl.sv
// Multi-cycle adder: reuses one CHUNK-bit ripple slice over WIDTH/CHUNK cycles, LSB chunk first.
// Optional subtract mode (A + ~B + 1) is enabled by defining MULTI_CYCLE_ADDER_SUB_EN.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module multi_cycle_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NP = 1 << CW;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_result;
    logic             r_ready;
    logic             r_valid;
    logic             r_busy;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    logic             r_sub;
`endif

    // Chunk tables padded to a power of two so the counter indexes them cleanly.
    logic [CHUNK-1:0] w_a_chunks [NP];
    logic [CHUNK-1:0] w_b_chunks [NP];
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_raw;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic [CHUNK:0]   w_c;
    logic             w_cout;

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_chunk
            if (gi < N) begin : g_real
                assign w_a_chunks[gi] = r_a[gi*CHUNK +: CHUNK];
                assign w_b_chunks[gi] = r_b[gi*CHUNK +: CHUNK];
            end else begin : g_pad
                assign w_a_chunks[gi] = '0;
                assign w_b_chunks[gi] = '0;
            end
        end
    endgenerate

    assign w_a_chunk = w_a_chunks[r_cnt];
    assign w_b_raw   = w_b_chunks[r_cnt];
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    assign w_b_chunk = w_b_raw ^ {CHUNK{r_sub}};
`else
    assign w_b_chunk = w_b_raw;
`endif

    assign w_c[0] = r_carry;
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            full_adder u_fa (
                .i_a   (w_a_chunk[gi]),
                .i_b   (w_b_chunk[gi]),
                .i_cin (w_c[gi]),
                .o_sum (w_sum[gi]),
                .o_cout(w_c[gi+1])
            );
        end
    endgenerate
    assign w_cout = w_c[CHUNK];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
            r_sub    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_add_term1;
                        r_b     <= i_add_term2;
                        r_cnt   <= '0;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
                        r_sub   <= i_sub;
                        r_carry <= i_sub;   // the "+1" of two's complement enters as carry-in
`else
                        r_carry <= 1'b0;
`endif
                        r_state <= S_ADD;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ADD: begin
                    for (int k = 0; k < N; k++) begin
                        if (r_cnt == CW'(k)) r_result[k*CHUNK +: CHUNK] <= w_sum;
                    end
                    r_carry <= w_cout;
                    if (r_cnt == CW'(N - 1)) begin
                        r_result[WIDTH] <= w_cout;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;
    assign o_result = r_result;
endmodule

// File: tb/tb_multi_cycle_adder_ctrl.sv
// Directed bench for multi_cycle_adder_ctrl: a CHUNK=2 instance (N=4) and a CHUNK=8 instance (N=1).
// Subtract vectors run only when MULTI_CYCLE_ADDER_SUB_EN is defined.

module tb_multi_cycle_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid0, valid1, ready;
    logic [7:0] a_in, b_in;
    logic       o_ready0, o_valid0, o_busy0;
    logic       o_ready1, o_valid1, o_busy1;
    logic [8:0] o_result0, o_result1;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    logic       sub_in;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_cycle_adder_ctrl #(.WIDTH(8), .CHUNK(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid0), .o_ready(o_ready0),
        .i_add_term1(a_in), .i_add_term2(b_in),
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        .i_sub(sub_in),
`endif
        .o_valid(o_valid0), .i_ready(ready), .o_result(o_result0), .o_busy(o_busy0)
    );

    multi_cycle_adder_ctrl #(.WIDTH(8), .CHUNK(8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(o_ready1),
        .i_add_term1(a_in), .i_add_term2(b_in),
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        .i_sub(sub_in),
`endif
        .o_valid(o_valid1), .i_ready(ready), .o_result(o_result1), .o_busy(o_busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // One complete transaction on the selected instance, accepted as soon as o_valid rises.
    task automatic do_op(input bit which, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input string tag);
        int lat;
        a_in = a;
        b_in = b;
        if (which) valid1 = 1'b1; else valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        valid1 = 1'b0;
        lat = 0;
        while (!(which ? o_valid1 : o_valid0) && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 16'(lat), which ? 16'd1 : 16'd4);
        check({tag, " result"}, 16'(which ? o_result1 : o_result0), 16'(exp));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({tag, " back idle"}, 16'(which ? o_ready1 : o_ready0), 16'd1);
    endtask

    initial begin
        int busy_cnt;
        int guard;
        logic [7:0] ra, rb;
        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; ready = 1'b0;
        a_in = '0; b_in = '0;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        sub_in = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        check("reset o_ready", 16'(o_ready0), 16'd1);
        check("reset o_valid", 16'(o_valid0), 16'd0);
        check("reset o_busy", 16'(o_busy0), 16'd0);
        check("reset o_result", 16'(o_result0), 16'h000);

        // FF + 01: carry ripples through every chunk
        a_in = 8'hFF; b_in = 8'h01; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        check("ff+01 o_ready in ADD", 16'(o_ready0), 16'd0);
        busy_cnt = 0;
        while (o_busy0 && busy_cnt < 50) begin
            busy_cnt++;
            tick();
        end
        check("ff+01 busy cycles", 16'(busy_cnt), 16'd4);
        check("ff+01 o_valid", 16'(o_valid0), 16'd1);
        check("ff+01 result", 16'(o_result0), 16'h100);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("ff+01 o_valid dropped", 16'(o_valid0), 16'd0);
        check("ff+01 o_ready back", 16'(o_ready0), 16'd1);

        // FF + FF with consumer back-pressure
        a_in = 8'hFF; b_in = 8'hFF; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        a_in = 8'h00; b_in = 8'h00;
        guard = 0;
        while (!o_valid0 && guard < 50) begin tick(); guard++; end
        check("ff+ff latency", 16'(guard), 16'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ff+ff hold%0d valid", i), 16'(o_valid0), 16'd1);
            check($sformatf("ff+ff hold%0d result", i), 16'(o_result0), 16'h1FE);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("ff+ff idle o_ready", 16'(o_ready0), 16'd1);
        check("ff+ff idle o_valid", 16'(o_valid0), 16'd0);

        // Second request during ADD must be ignored
        a_in = 8'h05; b_in = 8'h0A; valid0 = 1'b1;
        tick();
        a_in = 8'h12; b_in = 8'h34;
        guard = 0;
        while (!o_valid0 && guard < 50) begin
            check($sformatf("05+0a o_ready busy%0d", guard), 16'(o_ready0), 16'd0);
            tick();
            valid0 = 1'b0;
            guard++;
        end
        valid0 = 1'b0;
        check("05+0a latency", 16'(guard), 16'd4);
        check("05+0a result", 16'(o_result0), 16'h00F);
        check("05+0a o_ready in DONE", 16'(o_ready0), 16'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick(); tick();
        check("05+0a nothing queued busy", 16'(o_busy0), 16'd0);
        check("05+0a nothing queued valid", 16'(o_valid0), 16'd0);

        // Reset during the second ADD cycle aborts the op
        a_in = 8'hAA; b_in = 8'h55; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort o_valid", 16'(o_valid0), 16'd0);
        check("abort o_ready", 16'(o_ready0), 16'd1);
        check("abort o_busy", 16'(o_busy0), 16'd0);
        for (int i = 0; i < 5; i++) tick();
        check("abort no late valid", 16'(o_valid0), 16'd0);
        do_op(1'b0, 8'h01, 8'h02, 9'h003, "01+02");

        // N=1 instance
        do_op(1'b1, 8'h80, 8'h80, 9'h100, "n1 80+80");
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(1'b1, ra, rb, 9'(ra) + 9'(rb), $sformatf("n1 rnd%0d %h+%h", i, ra, rb));
        end
        do_op(1'b0, 8'h3C, 8'hC4, 9'h100, "3c+c4");

`ifdef MULTI_CYCLE_ADDER_SUB_EN
        sub_in = 1'b1;
        do_op(1'b0, 8'h10, 8'h01, 9'h10F, "sub 10-01");
        do_op(1'b0, 8'h00, 8'h01, 9'h0FF, "sub 00-01");
        do_op(1'b1, 8'h00, 8'h01, 9'h0FF, "n1 sub 00-01");
        sub_in = 1'b0;
        do_op(1'b0, 8'h10, 8'h01, 9'h011, "add after sub");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
